// File: rtl/sipo_frame_loader_pkg.sv
// Shared constants for the serial frame loader: default word width and FSM state codes.
// Downstream blocks import DEFAULT_WIDTH so the register width stays in step with the loader.
package sipo_frame_loader_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/sipo_frame_loader_shift_reg_n.sv
// WIDTH-bit shift register with synchronous clear and shift enable; next value exposed.
// One-cycle update, no backpressure: shifts whenever en is high, clear has priority.
module shift_reg_n
    import sipo_frame_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    // MSB_FIRST shifts left so the first bit ends in the top position after WIDTH shifts.
    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = '0;
        end else if (en) begin
            q_next = MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sipo_frame_loader.sv
// Framed serial-to-parallel loader with optional even parity; load strobes one edge after the last bit.
// No backpressure: bits are taken whenever bit_valid is high, start aborts and restarts any frame.
module sipo_frame_loader
    import sipo_frame_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CW-1:0]      cnt;
    logic               par_acc;
    logic               sh_clr;
    logic               sh_en;
    logic               take_data;
    logic               par_bad;
    logic               last_bit;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   sh_next;
    logic [WIDTH-1:0]   word;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Without parity the final data bit is still in flight, so take the post-shift value.
    assign word = PARITY_EN ? sh_q : sh_next;

    shift_reg_n #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk    (clk),
        .rst    (res),
        .clr    (sh_clr),
        .en     (sh_en),
        .din    (serial_in),
        .q      (sh_q),
        .q_next (sh_next)
    );

    always_comb begin
        state_nxt = state;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;
        take_data = 1'b0;
        par_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    sh_clr    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    sh_clr = 1'b1;
                end else if (bit_valid) begin
                    sh_en = 1'b1;
                    if (last_bit) begin
                        if (PARITY_EN) begin
                            state_nxt = ST_PARITY;
                        end else begin
                            state_nxt = ST_DONE;
                            take_data = 1'b1;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    sh_clr    = 1'b1;
                end else if (bit_valid) begin
                    state_nxt = ST_DONE;
                    if (par_acc ^ serial_in) begin
                        par_bad = 1'b1;
                    end else begin
                        take_data = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    sh_clr    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // load/parity_err are set on entry to DONE so they are high exactly for the DONE cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            par_acc    <= 1'b0;
            data_out   <= '0;
            load       <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            load       <= take_data;
            parity_err <= par_bad;
            busy       <= (state_nxt != ST_IDLE);
            if (take_data) begin
                data_out <= word;
            end
            if (sh_clr) begin
                cnt     <= '0;
                par_acc <= 1'b0;
            end else if (sh_en) begin
                cnt     <= cnt + 1'b1;
                par_acc <= par_acc ^ serial_in;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_loader.sv
// Bench for the frame loader: MSB-first, LSB-first and no-parity instances share one serial stream.
module tb_sipo_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res, start, bit_valid, serial_in;
    logic [7:0] dout_m, dout_l, dout_n;
    logic       load_m, load_l, load_n;
    logic       busy_m, busy_l, busy_n;
    logic       perr_m, perr_l, perr_n;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_m, exp_l, exp_n;
    int exp_ld_m = 0, exp_ld_n = 0, exp_pe = 0;
    int n_ld_m = 0, n_ld_l = 0, n_ld_n = 0, n_pe_m = 0, n_pe_l = 0;
    bit mon_on = 1'b0;

    sipo_frame_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_msb (
        .clk(clk), .res(res), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
        .data_out(dout_m), .load(load_m), .busy(busy_m), .parity_err(perr_m));

    sipo_frame_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_lsb (
        .clk(clk), .res(res), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
        .data_out(dout_l), .load(load_l), .busy(busy_l), .parity_err(perr_l));

    sipo_frame_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_np (
        .clk(clk), .res(res), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
        .data_out(dout_n), .load(load_n), .busy(busy_n), .parity_err(perr_n));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Per-cycle observer: strobe counts and load/parity_err exclusivity.
    always @(negedge clk) begin
        if (mon_on) begin
            n_ld_m += int'(load_m);
            n_ld_l += int'(load_l);
            n_ld_n += int'(load_n);
            n_pe_m += int'(perr_m);
            n_pe_l += int'(perr_l);
            check("excl_msb", 32'(load_m & perr_m), 32'd0);
            check("np_no_perr", 32'(perr_n), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int gap);
        repeat (gap) begin
            bit_valid = 1'b0;
            serial_in = 1'($urandom);
            tick();
        end
        bit_valid = 1'b1;
        serial_in = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic issue_start();
        start     = 1'b1;
        bit_valid = 1'($urandom);
        serial_in = 1'($urandom);
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        check("start_busy", 32'(busy_m), 32'd1);
        check("start_load", 32'(load_m), 32'd0);
        check("start_perr", 32'(perr_l), 32'd0);
    endtask

    task automatic abort_partial(input int k);
        issue_start();
        for (int i = 0; i < k; i++) drive_bit(1'($urandom), $urandom_range(0, 2));
    endtask

    // gap < 0 picks a random gap before every bit; chain leaves the DONE cycle for the caller's start.
    task automatic send_frame(input logic [7:0] ser, input logic p, input int gap, input bit chain);
        bit good;
        good = (p == ^ser);
        issue_start();
        for (int i = 7; i >= 0; i--) begin
            drive_bit(ser[i], (gap < 0) ? $urandom_range(0, 3) : gap);
            if (i > 0) check("mid_load", 32'(load_m), 32'd0);
        end
        exp_n = ser;
        exp_ld_n++;
        check("np_load", 32'(load_n), 32'd1);
        check("np_data", 32'(dout_n), 32'(exp_n));
        check("par_wait_busy", 32'(busy_m), 32'd1);
        check("par_wait_load", 32'(load_m), 32'd0);
        drive_bit(p, (gap < 0) ? $urandom_range(0, 3) : gap);
        if (good) begin
            exp_m = ser;
            exp_l = rev8(ser);
            exp_ld_m++;
        end else begin
            exp_pe++;
        end
        check("load_msb", 32'(load_m), 32'(good));
        check("load_lsb", 32'(load_l), 32'(good));
        check("perr_msb", 32'(perr_m), 32'(!good));
        check("perr_lsb", 32'(perr_l), 32'(!good));
        check("data_msb", 32'(dout_m), 32'(exp_m));
        check("data_lsb", 32'(dout_l), 32'(exp_l));
        check("done_busy", 32'(busy_m), 32'd1);
        check("np_idle_busy", 32'(busy_n), 32'd0);
        if (!chain) begin
            bit_valid = 1'b0;
            serial_in = 1'($urandom);
            tick();
            check("busy_fall", 32'(busy_m), 32'd0);
            check("load_one_cycle", 32'(load_m), 32'd0);
            check("perr_one_cycle", 32'(perr_m), 32'd0);
            check("hold_msb", 32'(dout_m), 32'(exp_m));
        end
    endtask

    initial begin
        logic [7:0] w;
        bit         c;
        int         base;

        res = 1'b1; start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
        exp_m = 8'h00; exp_l = 8'h00; exp_n = 8'h00;
        repeat (3) tick();
        check("rst_data", 32'(dout_m), 32'd0);
        check("rst_load", 32'(load_m), 32'd0);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_perr", 32'(perr_m), 32'd0);
        check("rst_data_np", 32'(dout_n), 32'd0);
        res = 1'b0;
        mon_on = 1'b1;
        tick();

        send_frame(8'hA5, 1'b0, 0, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        check("perr_keeps_a5", 32'(dout_m), 32'hA5);

        send_frame(8'h80, 1'b1, 3, 1'b0);
        check("gap_msb_80", 32'(dout_m), 32'h80);
        check("gap_lsb_01", 32'(dout_l), 32'h01);

        base = n_ld_m;
        abort_partial(4);
        send_frame(8'h5A, 1'b0, 0, 1'b0);
        check("restart_one_load", 32'(n_ld_m - base), 32'd1);
        check("restart_5a", 32'(dout_m), 32'h5A);

        issue_start();
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom), 0);
        res = 1'b1;
        tick();
        res = 1'b0;
        exp_m = 8'h00; exp_l = 8'h00; exp_n = 8'h00;
        check("midrst_data", 32'(dout_m), 32'd0);
        check("midrst_busy", 32'(busy_m), 32'd0);
        check("midrst_load", 32'(load_m), 32'd0);
        check("midrst_data_np", 32'(dout_n), 32'd0);
        send_frame(8'hFF, 1'b0, 0, 1'b0);

        base = n_ld_m;
        send_frame(8'h12, 1'b0, 0, 1'b1);
        send_frame(8'h34, 1'b1, 0, 1'b0);
        check("b2b_two_loads", 32'(n_ld_m - base), 32'd2);
        check("b2b_34", 32'(dout_m), 32'h34);

        for (int f = 0; f < 40; f++) begin
            w = 8'($urandom);
            c = (f < 39) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 4) == 0) abort_partial($urandom_range(0, 7));
            send_frame(w, (^w) ^ ($urandom_range(0, 3) == 0), -1, c);
            if (!c) begin
                repeat ($urandom_range(0, 2)) begin
                    bit_valid = 1'($urandom);
                    serial_in = 1'($urandom);
                    tick();
                    check("idle_hold", 32'(dout_m), 32'(exp_m));
                    check("idle_load", 32'(load_m), 32'd0);
                end
                bit_valid = 1'b0;
            end
        end

        tick();
        check("total_ld_msb", 32'(n_ld_m), 32'(exp_ld_m));
        check("total_ld_lsb", 32'(n_ld_l), 32'(exp_ld_m));
        check("total_ld_np", 32'(n_ld_n), 32'(exp_ld_n));
        check("total_pe_msb", 32'(n_pe_m), 32'(exp_pe));
        check("total_pe_lsb", 32'(n_pe_l), 32'(exp_pe));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sipo_frame_loader.md
Name: sipo_frame_loader

Overview:
- Serial-in/parallel-out deserializer that sits directly upstream of the 8-bit enabled register.
- Collects a framed serial word, checks optional even parity, and presents the word on data_out with a one-cycle load strobe.
- data_out drives the register's parallel input and load drives its enable, so the register captures one complete, parity-clean word per frame.

Parameters:
- WIDTH, 8: data bits per frame; must match the downstream register width.
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
- PARITY_EN, 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- res  input  1  reset, synchronous, active-high.
- start  input  1  frame start request.
- bit_valid  input  1  serial_in holds a valid bit this cycle.
- serial_in  input  1  serial data bit.
- data_out  output  WIDTH  last accepted word (registered).
- load  output  1  one-cycle strobe; data_out is new and valid in this cycle.
- busy  output  1  a frame is in progress.
- parity_err  output  1  one-cycle pulse on a parity mismatch.

Behaviour:
- Reset (res=1 at posedge clk):
  - State goes to IDLE; bit counter and shift register clear to 0.
  - data_out=0, load=0, busy=0, parity_err=0.
  - res has priority over every other input and applies in any state, including mid-frame.
- States: IDLE, SHIFT, PARITY, DONE. All outputs are registered.
- IDLE:
  - busy=0.
  - start=1 -> SHIFT; counter=0; shift register cleared.
  - bit_valid is ignored in the cycle start is taken.
- SHIFT:
  - busy=1.
  - Each cycle with bit_valid=1: serial_in is shifted in (direction per MSB_FIRST) and the counter increments.
  - Cycles with bit_valid=0 hold all state; any gap length is allowed.
  - On the WIDTH-th accepted bit: -> PARITY if PARITY_EN=1, else -> DONE.
- PARITY:
  - busy=1.
  - On bit_valid=1: err = (XOR of all data bits) XOR serial_in, then -> DONE.
- DONE (exactly one cycle, busy=1):
  - err=0 or PARITY_EN=0: data_out <= shift register and load=1 in that same cycle.
  - err=1: parity_err=1 for that one cycle, load stays 0, data_out is unchanged.
  - Next state is IDLE, unless start=1 in this cycle, in which case -> SHIFT directly (back-to-back frames, no idle cycle).
- Latency: load rises on the clock edge after the cycle in which the final bit (data or parity) is accepted.
- Restart: start=1 while in SHIFT or PARITY aborts the current frame.
  - Counter and shift register clear; state stays or returns to SHIFT.
  - No load, no parity_err is produced for the aborted frame.
- Between frames, data_out holds its last loaded value indefinitely.
- load and parity_err are never high in the same cycle.

Decomposition:
- State encoding (IDLE/SHIFT/PARITY/DONE) and the default WIDTH go as localparams in the shared definitions include, alongside the combinational library, so downstream blocks use the same width constant.
- One sub-module is natural: shift_reg_n, a WIDTH-bit shift register with synchronous clear, shift enable and a direction parameter.
- The FSM, bit counter and parity accumulator stay in the top module.

Test Plan:
- Nominal frame: reset, then MSB_FIRST=1, PARITY_EN=1, start, bits 1,0,1,0,0,1,0,1, parity 0 -> load=1 for exactly one cycle, data_out=0xA5, parity_err=0, busy falls the following cycle.
- Parity error: after the nominal frame, send 0x3C with parity bit 1 -> parity_err=1 for one cycle, load=0, data_out remains 0xA5.
- Bit gaps and direction: bits 1,0,0,0,0,0,0,0 with 3-cycle bit_valid gaps between bits, run with MSB_FIRST=1 and MSB_FIRST=0 (parity bit 1 in both runs) -> data_out=0x80 and 0x01 respectively; load arrives one edge after the parity bit.
- Restart: start, 4 bits, start again, full frame 0x5A (parity 0) -> exactly one load, data_out=0x5A.
- Reset mid-frame: res=1 after 5 bits -> on the next edge data_out=0, busy=0, load=0; a subsequent frame 0xFF (parity 0) loads 0xFF.
- Back-to-back frames: start asserted in the DONE cycle of frame 0x12 (parity 0), then frame 0x34 (parity 1) -> two load pulses with no idle cycle between frames, data_out 0x12 then 0x34.
